// File: rtl/mux8_scan_ctrl_if.sv
// Scanner-side bundle: command inputs, mux feedback and scan results.
// The master side commands scans and models the mux. The slave side is the scanner.
interface mux8_scan_ctrl_if;
    logic       start;
    logic [7:0] mask;
    logic       abort;
    logic       mux_y;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic [7:0] frame;

    modport master (
        output start, mask, abort, mux_y,
        input  sel, sel_valid, busy, done, frame
    );

    modport slave (
        input  start, mask, abort, mux_y,
        output sel, sel_valid, busy, done, frame
    );
endinterface

// File: rtl/mux8_scan_ctrl.sv
// Walks the enabled channels of an 8-to-1 mux in ascending order.
// Each channel is held for DWELL cycles, then sampled into frame.
module mux8_scan_ctrl #(
    parameter int DWELL = 1
) (
    input  logic               clk,
    input  logic               rst,
    mux8_scan_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(DWELL - 1);

    state_t     state;
    logic [7:0] pending;
    logic [3:0] cnt;
    logic [7:0] remain;

    // Channels still to visit once the current one has been sampled.
    always_comb begin
        remain = pending & ~(8'h01 << bus.sel);
    end

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= 8'h00;
            cnt           <= 4'd0;
            bus.sel       <= 3'd0;
            bus.sel_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.frame     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.frame <= 8'h00;
                        bus.busy  <= 1'b1;
                        if (bus.mask != 8'h00) begin
                            pending       <= bus.mask;
                            bus.sel       <= lowest(bus.mask);
                            cnt           <= 4'd0;
                            bus.sel_valid <= 1'b1;
                            state         <= SCAN;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                SCAN: begin
                    // Abort wins over a coincident sample edge: nothing is captured.
                    if (bus.abort) begin
                        pending       <= 8'h00;
                        cnt           <= 4'd0;
                        bus.sel_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else if (cnt == LAST) begin
                        bus.frame[bus.sel] <= bus.mux_y;
                        pending            <= remain;
                        cnt                <= 4'd0;
                        if (remain != 8'h00) begin
                            bus.sel <= lowest(remain);
                        end else begin
                            bus.sel_valid <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    pending  <= 8'h00;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: three instances with DWELL = 1, 2, 3, each fed by a model mux.
module tb_mux8_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_v [3];
    logic [7:0] mask_v  [3];
    logic       abort_v [3];
    logic [7:0] pat     [3];
    logic [2:0] sel_w   [3];
    logic       sv_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] frame_w [3];

    for (genvar g = 0; g < 3; g++) begin : u
        mux8_scan_ctrl_if bus ();
        mux8_scan_ctrl #(.DWELL(g + 1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
        assign bus.start  = start_v[g];
        assign bus.mask   = mask_v[g];
        assign bus.abort  = abort_v[g];
        assign bus.mux_y  = pat[g][bus.sel];
        assign sel_w[g]   = bus.sel;
        assign sv_w[g]    = bus.sel_valid;
        assign busy_w[g]  = bus.busy;
        assign done_w[g]  = bus.done;
        assign frame_w[g] = bus.frame;
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] frame_q[$];
    logic [2:0] sel_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, ".sel"},       32'(sel_w[d]),   32'h0);
        chk({tag, ".sel_valid"}, 32'(sv_w[d]),    32'h0);
        chk({tag, ".busy"},      32'(busy_w[d]),  32'h0);
        chk({tag, ".done"},      32'(done_w[d]),  32'h0);
        chk({tag, ".frame"},     32'(frame_w[d]), 32'h0);
    endtask

    // Entry/exit: just after a rising edge. mid_start >= 0 pulses start (with a junk mask) mid-scan.
    task automatic run_scan(input int d, input logic [7:0] m, input logic [7:0] p,
                            input int mid_start, input string tag);
        int n;
        int k;
        pat[d] = p;
        k = $countones(m);
        frame_q.push_back(m & p);
        for (int c = 0; c < 8; c++)
            if (m[c]) for (int r = 0; r <= d; r++) sel_q.push_back(3'(c));
        start_v[d] = 1'b1;
        mask_v[d]  = m;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        n = 0;
        while (done_w[d] !== 1'b1 && n < 200) begin
            if (sv_w[d] === 1'b1) begin
                if (sel_q.size() > 0) chk({tag, ".sel"}, 32'(sel_w[d]), 32'(sel_q.pop_front()));
                else chk({tag, ".sel_extra"}, 32'(sel_w[d]), 32'hFFFF);
            end
            if (n == mid_start) begin
                start_v[d] = 1'b1;
                mask_v[d]  = 8'h01;
            end else if (n == mid_start + 1) begin
                start_v[d] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_v[d] = 1'b0;
        chk({tag, ".done_cycle"}, 32'(n), 32'(k * (d + 1)));
        chk({tag, ".sel_left"}, 32'(sel_q.size()), 32'h0);
        sel_q.delete();
        chk({tag, ".frame"}, 32'(frame_w[d]), 32'(frame_q.pop_front()));
        @(posedge clk); #1;
        chk({tag, ".idle_done"}, 32'(done_w[d]), 32'h0);
        chk({tag, ".idle_busy"}, 32'(busy_w[d]), 32'h0);
    endtask

    initial begin
        int seen_done;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; mask_v[d] = 8'h00; abort_v[d] = 1'b0; pat[d] = 8'h00;
        end
        #12;
        chk_reset(0, "rst0");
        chk_reset(2, "rst2");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-scan on the DWELL=2 instance.
        pat[1] = 8'hFF;
        start_v[1] = 1'b1; mask_v[1] = 8'hFF;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("midscan.busy_before", 32'(busy_w[1]), 32'h1);
        rst = 1'b1;
        #1;
        chk_reset(1, "midscan");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_scan(1, 8'h01, 8'hFF, -1, "after_rst");

        run_scan(0, 8'hFF, 8'hA5, -1, "full");
        run_scan(2, 8'b1001_0010, 8'hFF, -1, "sparse");
        run_scan(0, 8'h00, 8'hFF, -1, "empty");
        run_scan(0, 8'h3C, 8'h5A, 2, "midstart");

        // Abort while sel==3 on the DWELL=1 instance.
        pat[0] = 8'hFF;
        frame_q.push_back(8'h07);
        start_v[0] = 1'b1; mask_v[0] = 8'hFF;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort.sel", 32'(sel_w[0]), 32'h3);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        chk("abort.busy",  32'(busy_w[0]), 32'h0);
        chk("abort.valid", 32'(sv_w[0]),   32'h0);
        chk("abort.frame", 32'(frame_w[0]), 32'(frame_q.pop_front()));
        seen_done = 0;
        repeat (12) begin
            if (done_w[0] === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        chk("abort.no_done", 32'(seen_done), 32'h0);
        chk("abort.frame_hold", 32'(frame_w[0]), 32'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
